full_adder_mux_cells: RTL and testbench

Leaf-cell bundle providing the three gate-level primitives every ALU bit slice is built from: `full_adder`, `mux2` and `mux8`. Each cell is purely combinational and built from delayed gate primitives (50 ps per gate, `timescale 1ps/1ps`). The top wrapper `full_adder_mux_cells` instantiates one of each and registers their outputs, so the cells can be characterised in a clocked environment. The ALU slice and the 64-bit ALU instantiate the leaf cells directly, not the wrapper.

---
 rtl/alu_pkg.sv | 14 +
 rtl/full_adder.sv | 22 ++
 rtl/mux2.sv | 20 ++
 rtl/mux4.sv | 23 ++
 rtl/mux8.sv | 26 ++
 rtl/full_adder_mux_cells.sv | 64 ++++++
 tb/tb_full_adder_mux_cells.sv | 180 ++++++++++++++++++
 7 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU leaf cells.
// Gate delay and ALU control encodings.
`timescale 1ps/1ps
package alu_pkg;
  localparam int GATE_DELAY = 50;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;
  localparam logic [2:0] ALU_PASS_A   = 3'b111;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder from delayed gates.
// Sum is two xor levels, carry three levels.
`timescale 1ps/1ps
module full_adder #(
  parameter int GATE_DELAY = alu_pkg::GATE_DELAY
) (
  input  logic A,
  input  logic B,
  input  logic carryin,
  output logic out,
  output logic carryout
);
  logic axb;
  logic ab;
  logic cx;

  xor #(GATE_DELAY) u_x1 (axb, A, B);
  xor #(GATE_DELAY) u_x2 (out, axb, carryin);
  and #(GATE_DELAY) u_a1 (ab, A, B);
  and #(GATE_DELAY) u_a2 (cx, carryin, axb);
  or  #(GATE_DELAY) u_o1 (carryout, ab, cx);
endmodule

// File: rtl/mux2.sv
// 2:1 mux from delayed gates.
// The deselected leg is forced to 0, so X there cannot leak.
`timescale 1ps/1ps
module mux2 #(
  parameter int GATE_DELAY = alu_pkg::GATE_DELAY
) (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic out
);
  logic nsel;
  logic pa;
  logic pb;

  not #(GATE_DELAY) u_n  (nsel, sel);
  and #(GATE_DELAY) u_aa (pa, a, nsel);
  and #(GATE_DELAY) u_ab (pb, b, sel);
  or  #(GATE_DELAY) u_o  (out, pa, pb);
endmodule

// File: rtl/mux4.sv
// 4:1 mux as a tree of three 2:1 muxes.
// sel[0] picks within pairs, sel[1] picks the pair.
`timescale 1ps/1ps
module mux4 #(
  parameter int GATE_DELAY = alu_pkg::GATE_DELAY
) (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);
  logic lo;
  logic hi;

  mux2 #(.GATE_DELAY(GATE_DELAY)) u_lo (
    .a(in[0]), .b(in[1]), .sel(sel[0]), .out(lo)
  );
  mux2 #(.GATE_DELAY(GATE_DELAY)) u_hi (
    .a(in[2]), .b(in[3]), .sel(sel[0]), .out(hi)
  );
  mux2 #(.GATE_DELAY(GATE_DELAY)) u_top (
    .a(lo), .b(hi), .sel(sel[1]), .out(out)
  );
endmodule

// File: rtl/mux8.sv
// 8:1 mux with enable: in[sel] when en, else 0.
// Two 4:1 halves, a 2:1 on sel[2], then gated by en.
`timescale 1ps/1ps
module mux8 #(
  parameter int GATE_DELAY = alu_pkg::GATE_DELAY
) (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  input  logic       en,
  output logic       out
);
  logic lo;
  logic hi;
  logic pick;

  mux4 #(.GATE_DELAY(GATE_DELAY)) u_lo (
    .in(in[3:0]), .sel(sel[1:0]), .out(lo)
  );
  mux4 #(.GATE_DELAY(GATE_DELAY)) u_hi (
    .in(in[7:4]), .sel(sel[1:0]), .out(hi)
  );
  mux2 #(.GATE_DELAY(GATE_DELAY)) u_top (
    .a(lo), .b(hi), .sel(sel[2]), .out(pick)
  );
  and #(GATE_DELAY) u_en (out, pick, en);
endmodule

// File: rtl/full_adder_mux_cells.sv
// Characterisation wrapper: one of each leaf cell
// with registered outputs and synchronous reset.
`timescale 1ps/1ps
module full_adder_mux_cells #(
  parameter int GATE_DELAY = alu_pkg::GATE_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fa_a,
  input  logic       fa_b,
  input  logic       fa_cin,
  output logic       fa_sum,
  output logic       fa_cout,
  input  logic       m2_a,
  input  logic       m2_b,
  input  logic       m2_sel,
  output logic       m2_out,
  input  logic [7:0] m8_in,
  input  logic [2:0] m8_sel,
  input  logic       m8_en,
  output logic       m8_out
);
  logic fa_sum_c, fa_cout_c, m2_c, m8_c;
  logic fa_sum_d, fa_cout_d, m2_out_d, m8_out_d;
  logic fa_sum_q, fa_cout_q, m2_out_q, m8_out_q;

  full_adder #(.GATE_DELAY(GATE_DELAY)) u_fa (
    .A(fa_a), .B(fa_b), .carryin(fa_cin),
    .out(fa_sum_c), .carryout(fa_cout_c)
  );
  mux2 #(.GATE_DELAY(GATE_DELAY)) u_m2 (
    .a(m2_a), .b(m2_b), .sel(m2_sel), .out(m2_c)
  );
  mux8 #(.GATE_DELAY(GATE_DELAY)) u_m8 (
    .in(m8_in), .sel(m8_sel), .en(m8_en), .out(m8_c)
  );

  // Next output values: reset wins over captured cell results.
  always_comb begin
    fa_sum_d  = fa_sum_c;
    fa_cout_d = fa_cout_c;
    m2_out_d  = m2_c;
    m8_out_d  = m8_c;
    if (reset) begin
      fa_sum_d  = 1'b0;
      fa_cout_d = 1'b0;
      m2_out_d  = 1'b0;
      m8_out_d  = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    fa_sum_q  <= fa_sum_d;
    fa_cout_q <= fa_cout_d;
    m2_out_q  <= m2_out_d;
    m8_out_q  <= m8_out_d;
  end

  assign fa_sum  = fa_sum_q;
  assign fa_cout = fa_cout_q;
  assign m2_out  = m2_out_q;
  assign m8_out  = m8_out_q;
endmodule

// File: tb/tb_full_adder_mux_cells.sv
// Self-checking bench for the wrapper and a slice-style
// leaf chain, against an arithmetic reference model.
`timescale 1ps/1ps
module tb_full_adder_mux_cells;
  logic       clk = 1'b0;
  logic       reset;
  logic       fa_a, fa_b, fa_cin;
  logic       fa_sum, fa_cout;
  logic       m2_a, m2_b, m2_sel;
  logic       m2_out;
  logic [7:0] m8_in;
  logic [2:0] m8_sel;
  logic       m8_en;
  logic       m8_out;

  int checks = 0;
  int errors = 0;

  always #5000 clk = ~clk;

  full_adder_mux_cells dut (
    .clk(clk), .reset(reset),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .m2_a(m2_a), .m2_b(m2_b), .m2_sel(m2_sel),
    .m2_out(m2_out),
    .m8_in(m8_in), .m8_sel(m8_sel), .m8_en(m8_en),
    .m8_out(m8_out)
  );

  // Slice-style chain: B through an inverting mux2,
  // into the adder, result picked by mux8.
  logic ca, cb, cb_n, ccin;
  logic mb, csum, ccout, cres;
  assign cb_n = ~cb;
  mux2 u_inv (.a(cb), .b(cb_n), .sel(1'b1), .out(mb));
  full_adder u_fa (
    .A(ca), .B(mb), .carryin(ccin),
    .out(csum), .carryout(ccout)
  );
  mux8 u_m8 (
    .in({ca, ca ^ mb, ca | mb, ca & mb,
         csum, csum, 1'b0, mb}),
    .sel(alu_pkg::ALU_SUBTRACT), .en(1'b1), .out(cres)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected registered outputs {fa_sum, fa_cout, m2, m8}
  function automatic logic [3:0] model(
    input logic r, input logic a, input logic b,
    input logic c, input logic ma, input logic mb2,
    input logic ms, input logic [7:0] mi,
    input logic [2:0] s, input logic e);
    int tot;
    logic [3:0] v;
    if (r) return 4'b0;
    tot = int'(a) + int'(b) + int'(c);
    v[3] = tot[0];
    v[2] = tot[1];
    v[1] = ms ? mb2 : ma;
    v[0] = e ? mi[s] : 1'b0;
    return v;
  endfunction

  logic [3:0] exp_q;

  // Capture model value for the inputs at the coming edge
  task automatic step(input string tag);
    exp_q = model(reset, fa_a, fa_b, fa_cin, m2_a, m2_b,
                  m2_sel, m8_in, m8_sel, m8_en);
    @(posedge clk);
    #1000;
    check(tag, {4'b0, fa_sum, fa_cout, m2_out, m8_out},
          {4'b0, exp_q});
    @(negedge clk);
  endtask

  task automatic drive_all(input logic [15:0] v);
    fa_a   = v[0];
    fa_b   = v[1];
    fa_cin = v[2];
    m2_a   = v[3];
    m2_b   = v[4];
    m2_sel = v[5];
    m8_in  = v[13:6];
    m8_sel = {v[15:14], v[0]};
    m8_en  = v[1] | v[2];
  endtask

  initial begin
    int tot;
    reset = 1'b1;
    drive_all(16'hFFFF);
    m8_sel = 3'd7;
    m8_en  = 1'b1;
    ca = 1'b0; cb = 1'b0; ccin = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #1000;
    check("reset_hold",
          {4'b0, fa_sum, fa_cout, m2_out, m8_out}, 8'h0);
    @(negedge clk);
    reset = 1'b0;
    step("reset_release");

    for (int i = 0; i < 8; i++) begin
      fa_a = i[0]; fa_b = i[1]; fa_cin = i[2];
      step("fa_exhaustive");
    end

    m2_a = 0; m2_b = 1; m2_sel = 0; step("mux2_a0b1s0");
    m2_sel = 1; step("mux2_a0b1s1");
    m2_a = 1; m2_b = 0; m2_sel = 0; step("mux2_a1b0s0");

    m8_in = 8'b1000_0001;
    m8_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      m8_sel = 3'(s);
      step("mux8_walk");
    end
    m8_in = 8'hFF;
    m8_en = 1'b0;
    for (int s = 0; s < 8; s++) begin
      m8_sel = 3'(s);
      step("mux8_disabled");
    end

    fa_a = 0; fa_b = 0; fa_cin = 0;
    step("latency_setup");
    fa_a = 1;
    #2000;
    check("latency_hold", {7'b0, fa_sum}, 8'h0);
    @(posedge clk);
    #1000;
    check("latency_capture", {7'b0, fa_sum}, 8'h1);
    @(negedge clk);

    drive_all(16'hFFFF);
    m8_sel = 3'd7;
    m8_en = 1'b1;
    reset = 1'b1;
    step("reset_midstream");
    reset = 1'b0;

    for (int i = 0; i < 200; i++) begin
      drive_all(16'($urandom));
      reset = ($urandom_range(0, 15) == 0);
      step("random");
    end
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ca = i[0]; cb = i[1]; ccin = i[2];
      #1000;
      tot = int'(ca) + int'(!cb) + int'(ccin);
      check("slice_sum", {7'b0, cres}, {7'b0, tot[0]});
      check("slice_cout", {7'b0, ccout}, {7'b0, tot[1]});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #50000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
